updown_sweep_ctrl: RTL and testbench
====================================

# updown_sweep_ctrl

Sequencer for the team's up/down counter datapath. Accepts sweep commands over a valid/ready handshake: bounds, mode and pass count. Drives an internal WIDTH-bit up/down count through those bounds, and reports busy, done and command errors. Sits between the configuration/control logic and any consumer of the count value; supports pause and abort.

## Interface
- WIDTH, 4, width of count and bounds
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE and while reset is low
- cmd_lo  in  WIDTH  lower bound (inclusive)
- cmd_hi  in  WIDTH  upper bound (inclusive)
- cmd_mode  in  2  00 up-restart, 01 down-restart, 10 ping-pong, 11 reserved
- cmd_passes  in  4  number of passes; 0 = run until abort
- pause  in  1  freeze count, direction and pass counter while in RUN
- abort  in  1  terminate sweep, no done
- count  out  WIDTH  current count
- up_down  out  1  current direction, 1 = up
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse on rejected command

## Operation
- States: IDLE, RUN, DONE. Async reset forces IDLE, count=0, up_down=1, busy=0, done=0, err=0.
- Accept: cmd_valid & cmd_ready at an edge. All cmd_* fields are sampled there.
- Reject: if cmd_lo > cmd_hi or cmd_mode=11, then at that edge err=1 for one cycle, state stays IDLE, and count and up_down are unchanged.
- Valid accept: state goes to RUN and the remaining-pass register is loaded with cmd_passes.
  - Modes 00 and 10 set count=lo, up_down=1.
  - Mode 01 sets count=hi, up_down=0.
- Endpoint: count==hi while up_down=1, or count==lo while up_down=0. The start value is not an endpoint unless lo==hi (mode 10) or the start is already the endpoint.
- Edge priority in RUN, highest first:
  1. abort: go to IDLE; count and up_down hold; no done.
  2. pause: everything holds.
  3. Endpoint with remaining==1: go to DONE; count holds.
  4. Endpoint, otherwise: decrement remaining (unless passes=0, infinite).
     - Mode 00: count set to lo.
     - Mode 01: count set to hi.
     - Mode 10: flip up_down and step one in the new direction on the same edge. If lo==hi, count holds.
  5. Not at endpoint: count steps by ±1 per up_down.
- DONE: lasts exactly one cycle with done=1, then IDLE. abort in DONE has no effect.
- In IDLE, abort and pause are ignored. abort coincident with an accept does not cancel the accept.
- Arithmetic is unsigned WIDTH-bit. Count never leaves [lo,hi] during RUN, so no modular wrap occurs.

## Timing
- cmd_ready is combinational from state; it falls the cycle after an accept.
- First sweep value appears on count in the cycle after the accept edge.
- Completion: with no pauses, modes 00 and 01 produce passes×(hi−lo+1) RUN cycles.
- Mode 10: the first pass lasts (hi−lo+1) cycles and each later pass (hi−lo) cycles; a later pass lasts 1 cycle when lo==hi.
- done is asserted in the cycle following the last endpoint cycle. cmd_ready returns 1 the cycle after done.
- Each cycle with pause=1 adds one cycle to completion latency.
- Reset asserted mid-sweep: outputs take their reset values immediately (asynchronously); no done pulse.

## Test plan
- Reset then mode 00, lo=2, hi=5, passes=2 → count 2,3,4,5,2,3,4,5; busy=1 for 8 cycles; done for 1 cycle with count=5; cmd_ready=1 in the next cycle.
- Mode 10, lo=1, hi=3, passes=3 → count 1,2,3,2,1,2,3; up_down flips after each 3 and 1; done follows the last 3.
- Mode 01, lo=0, hi=15, passes=1 → count 15 down to 0 with up_down=0; done after 16 RUN cycles.
- Reject cases: lo=6, hi=4 → err pulse, state stays IDLE, count unchanged. mode=11 → err pulse, state stays IDLE, count unchanged.
- Pause and abort:
  - Mode 00, lo=0, hi=7, passes=0: pause held 3 cycles at count=4 → count stays 4 for 3 cycles.
  - abort at count=6 → IDLE next cycle, count=6, no done.
- Edge cases:
  - Mode 10, lo=hi=9, passes=4 → count=9 throughout, up_down toggles each cycle, done after 4 RUN cycles.
  - Reset asserted mid-sweep → count=0, busy=0 immediately.

Source files
------------

// File: rtl/updown_sweep_ctrl_if.sv
// Command and status bundle between the sweep controller and the logic that configures it.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready; the
// master holds cmd_* stable while cmd_valid is high, and cmd_ready never depends on cmd_valid.
interface updown_sweep_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_lo;
  logic [WIDTH-1:0] cmd_hi;
  logic [1:0]       cmd_mode;
  logic [3:0]       cmd_passes;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             up_down;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_lo, cmd_hi, cmd_mode, cmd_passes, pause, abort,
    input  cmd_ready, count, up_down, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_lo, cmd_hi, cmd_mode, cmd_passes, pause, abort,
    output cmd_ready, count, up_down, busy, done, err
  );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep sequencer: takes bounds/mode/pass-count commands and walks a count
// through them, with pause, abort, a one-cycle done pulse and a one-cycle error pulse.
module updown_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_sweep_ctrl_if.slave   bus,
  output logic [1:0]           state_o
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       rem_q, rem_d;
  logic             up_q, up_d;
  logic             err_q, err_d;
  logic             at_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= 2'b00;
      rem_q   <= 4'd0;
      up_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      up_q    <= up_d;
      err_q   <= err_d;
    end
  end

  assign at_end = up_q ? (count_q == hi_q) : (count_q == lo_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    up_d    = up_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if ((bus.cmd_lo > bus.cmd_hi) || (bus.cmd_mode == 2'b11)) begin
            err_d = 1'b1;
          end else begin
            state_d = S_RUN;
            lo_d    = bus.cmd_lo;
            hi_d    = bus.cmd_hi;
            mode_d  = bus.cmd_mode;
            rem_d   = bus.cmd_passes;
            if (bus.cmd_mode == 2'b01) begin
              count_d = bus.cmd_hi;
              up_d    = 1'b0;
            end else begin
              count_d = bus.cmd_lo;
              up_d    = 1'b1;
            end
          end
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.pause) begin
          state_d = S_RUN;
        end else if (at_end && (rem_q == 4'd1)) begin
          state_d = S_DONE;
        end else if (at_end) begin
          // A zero pass count means run forever, so it is never decremented.
          if (rem_q != 4'd0) rem_d = rem_q - 4'd1;
          case (mode_q)
            2'b00:   count_d = lo_q;
            2'b01:   count_d = hi_q;
            default: begin
              up_d = ~up_q;
              if (lo_q != hi_q) count_d = up_q ? (count_q - 1'b1) : (count_q + 1'b1);
            end
          endcase
        end else begin
          count_d = up_q ? (count_q + 1'b1) : (count_q - 1'b1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == S_IDLE) && !reset;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
  assign bus.count     = count_q;
  assign bus.up_down   = up_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: directed and random sweeps checked cycle by cycle against
// a list of expected (direction, count) values built from the sweep rules.
module tb_updown_sweep_ctrl;
  localparam int W = 4;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         checks;
  int         failures;
  logic [W:0] exp_q[$];
  logic [W-1:0] model_count;
  logic         model_up;

  updown_sweep_ctrl_if #(.WIDTH(W)) bus ();

  updown_sweep_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected RUN-cycle values, one entry per cycle: {up_down, count}
  task automatic build_model(input int lo, input int hi, input int mode, input int n);
    exp_q.delete();
    for (int p = 0; p < n; p++) begin
      if (mode == 0) begin
        for (int v = lo; v <= hi; v++) exp_q.push_back({1'b1, v[W-1:0]});
      end else if (mode == 1) begin
        for (int v = hi; v >= lo; v--) exp_q.push_back({1'b0, v[W-1:0]});
      end else if (p == 0) begin
        for (int v = lo; v <= hi; v++) exp_q.push_back({1'b1, v[W-1:0]});
      end else if (lo == hi) begin
        exp_q.push_back({(p % 2 == 0), lo[W-1:0]});
      end else if (p % 2 == 1) begin
        for (int v = hi - 1; v >= lo; v--) exp_q.push_back({1'b0, v[W-1:0]});
      end else begin
        for (int v = lo + 1; v <= hi; v++) exp_q.push_back({1'b1, v[W-1:0]});
      end
    end
  endtask

  // Driver: present one command for one edge; pause/abort levels alongside it are ignored in IDLE.
  task automatic send_cmd(input int lo, input int hi, input int mode, input int passes,
                          input bit pz, input bit ab);
    @(negedge clk);
    check("cmd_ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_lo     = lo[W-1:0];
    bus.cmd_hi     = hi[W-1:0];
    bus.cmd_mode   = mode[1:0];
    bus.cmd_passes = passes[3:0];
    bus.pause      = pz;
    bus.abort      = ab;
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.pause      = 1'b0;
    bus.abort      = 1'b0;
    bus.cmd_lo     = W'($urandom);
    bus.cmd_hi     = W'($urandom);
    bus.cmd_mode   = 2'($urandom);
    bus.cmd_passes = 4'($urandom);
  endtask

  task automatic run_sweep(input int lo, input int hi, input int mode, input int passes,
                           input int pause_pct, input int pause_start, input int pause_len,
                           input int abort_at);
    logic [W:0] last;
    bit do_pause, do_abort, finished;
    int cyc;
    build_model(lo, hi, mode, (passes == 0) ? 3 : passes);
    send_cmd(lo, hi, mode, passes, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cyc = 0;
    finished = 1'b0;
    last = exp_q[0];
    while (!finished && cyc < 400) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("done_pulse", bus.done, 1);
        check("done_busy", bus.busy, 0);
        check("done_count", bus.count, last[W-1:0]);
        @(negedge clk);
        check("done_clear", bus.done, 0);
        check("ready_after_done", bus.cmd_ready, 1);
        model_count = last[W-1:0];
        model_up    = last[W];
        finished    = 1'b1;
      end else begin
        check("run_busy", bus.busy, 1);
        check("run_done", bus.done, 0);
        check("run_count", bus.count, exp_q[0][W-1:0]);
        check("run_up_down", bus.up_down, exp_q[0][W]);
        last = exp_q[0];
        do_pause = ((cyc >= pause_start) && (cyc < pause_start + pause_len)) ||
                   ($urandom_range(0, 99) < pause_pct);
        do_abort = (cyc == abort_at);
        bus.pause = do_pause;
        bus.abort = do_abort;
        @(posedge clk);
        #1;
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        if (do_abort) begin
          @(negedge clk);
          check("abort_busy", bus.busy, 0);
          check("abort_no_done", bus.done, 0);
          check("abort_count", bus.count, last[W-1:0]);
          check("abort_up_down", bus.up_down, last[W]);
          check("abort_ready", bus.cmd_ready, 1);
          model_count = last[W-1:0];
          model_up    = last[W];
          exp_q.delete();
          finished = 1'b1;
        end else if (!do_pause) begin
          void'(exp_q.pop_front());
        end
        cyc++;
      end
    end
    check("sweep_within_budget", finished, 1);
    exp_q.delete();
  endtask

  task automatic reject_cmd(input int lo, input int hi, input int mode, input int passes);
    send_cmd(lo, hi, mode, passes, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    check("reject_err", bus.err, 1);
    check("reject_busy", bus.busy, 0);
    check("reject_ready", bus.cmd_ready, 1);
    check("reject_count", bus.count, model_count);
    check("reject_up_down", bus.up_down, model_up);
    @(negedge clk);
    check("reject_err_clear", bus.err, 0);
  endtask

  initial begin
    int lo, hi;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_lo = '0;
    bus.cmd_hi = '0;
    bus.cmd_mode = 2'b00;
    bus.cmd_passes = 4'd0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    model_count = '0;
    model_up = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_count", bus.count, 0);
    check("rst_up_down", bus.up_down, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_ready_low", bus.cmd_ready, 0);
    reset = 1'b0;

    // Directed sweeps
    run_sweep(2, 5, 0, 2, 0, -1, 0, -1);
    run_sweep(1, 3, 2, 3, 0, -1, 0, -1);
    run_sweep(0, 15, 1, 1, 0, -1, 0, -1);
    reject_cmd(6, 4, 0, 1);
    reject_cmd(2, 5, 3, 2);
    run_sweep(0, 7, 0, 0, 0, 4, 3, 9);
    reject_cmd(9, 8, 2, 1);
    run_sweep(9, 9, 2, 4, 0, -1, 0, -1);
    run_sweep(0, 15, 1, 2, 0, 15, 2, -1);

    // Reset in the middle of a sweep takes effect without waiting for a clock edge
    send_cmd(3, 12, 0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_count", bus.count, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_up_down", bus.up_down, 1);
    check("midrst_done", bus.done, 0);
    check("midrst_ready", bus.cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    model_count = '0;
    model_up = 1'b1;
    @(negedge clk);
    check("postrst_ready", bus.cmd_ready, 1);
    check("postrst_done", bus.done, 0);

    // Random sweeps with random pauses
    for (int i = 0; i < 10; i++) begin
      lo = $urandom_range(0, 15);
      hi = $urandom_range(lo, 15);
      run_sweep(lo, hi, $urandom_range(0, 2), $urandom_range(1, 3), 20, -1, 0, -1);
      if ($urandom_range(0, 2) == 0) reject_cmd(hi, lo - 1 + (lo == 0 ? 16 : 0), 3, 1);
    end
    for (int i = 0; i < 3; i++) begin
      lo = $urandom_range(0, 15);
      hi = $urandom_range(lo, 15);
      run_sweep(lo, hi, $urandom_range(0, 2), 0, 15, -1, 0, $urandom_range(0, hi - lo));
    end
    lo = $urandom_range(1, 15);
    reject_cmd(lo, lo - 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
